// File: rtl/neander_x_alu_seq_if.sv
// NEANDER-X sequential ALU request/result bundle.
// The control FSM is master; the ALU is slave.
interface neander_x_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             zero;
  logic             neg;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_op, a, b, carry_in,
    input  result, result_hi, carry_out,
    input  zero, neg, busy, done
  );

  modport slave (
    input  start, alu_op, a, b, carry_in,
    output result, result_hi, carry_out,
    output zero, neg, busy, done
  );
endinterface

// File: rtl/neander_x_alu_seq.sv
// NEANDER-X registered ALU with iterative MUL/DIV/MOD.
// NEANDER_ALU_ROT_EN turns opcode F into ROR-through-carry.
module neander_x_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst_n,
  neander_x_alu_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_NEG = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;
  localparam logic [3:0] OP_ADC = 4'hC;
  localparam logic [3:0] OP_SBC = 4'hD;
  localparam logic [3:0] OP_ASR = 4'hE;

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cy_q, cy_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   s_sum;
  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_cy, s_zok, iter_op;

  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   dsh;
  logic [WIDTH-1:0] ddf;
  logic             ge;
  logic [WIDTH-1:0] st_acc, st_mq;

  // Single-cycle datapath, evaluated on the live operands
  always_comb begin
    s_sum = '0;
    s_res = '0;
    s_hi  = '0;
    s_cy  = 1'b0;
    s_zok = 1'b1;
    unique case (bus.alu_op)
      OP_ADD: begin
        s_sum = {1'b0, bus.a} + {1'b0, bus.b};
        s_res = s_sum[WIDTH-1:0];
        s_cy  = s_sum[WIDTH];
      end
      OP_ADC: begin
        s_sum = {1'b0, bus.a} + {1'b0, bus.b}
              + {{WIDTH{1'b0}}, bus.carry_in};
        s_res = s_sum[WIDTH-1:0];
        s_cy  = s_sum[WIDTH];
      end
      OP_SUB: begin
        s_sum = {1'b0, bus.a} - {1'b0, bus.b};
        s_res = s_sum[WIDTH-1:0];
        s_cy  = s_sum[WIDTH];
      end
      OP_SBC: begin
        s_sum = {1'b0, bus.a} - {1'b0, bus.b}
              - {{WIDTH{1'b0}}, bus.carry_in};
        s_res = s_sum[WIDTH-1:0];
        s_cy  = s_sum[WIDTH];
      end
      OP_AND: s_res = bus.a & bus.b;
      OP_OR:  s_res = bus.a | bus.b;
      OP_XOR: s_res = bus.a ^ bus.b;
      OP_NOT: s_res = ~bus.a;
      OP_SHL: begin
        s_res = {bus.a[WIDTH-2:0], 1'b0};
        s_cy  = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        s_res = {1'b0, bus.a[WIDTH-1:1]};
        s_cy  = bus.a[0];
      end
      OP_ASR: begin
        s_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
        s_cy  = bus.a[0];
      end
      OP_NEG: begin
        s_res = ~bus.a + 1'b1;
        s_cy  = |bus.a;
      end
      OP_DIV, OP_MOD: begin
        s_res = '1;
        s_hi  = bus.a;
        s_cy  = 1'b1;
      end
      OP_MUL: s_res = '0;
      default: begin
`ifdef NEANDER_ALU_ROT_EN
        s_res = {bus.carry_in, bus.a[WIDTH-1:1]};
        s_cy  = bus.a[0];
`else
        s_zok = 1'b0;
`endif
      end
    endcase
  end

  assign iter_op = (bus.alu_op == OP_MUL)
                 || (((bus.alu_op == OP_DIV)
                   || (bus.alu_op == OP_MOD))
                   && (|bus.b));

  // One shift-add or restoring-divide step
  always_comb begin
    madd   = {1'b0, acc_q}
           + {1'b0, mq_q[0] ? mb_q : {WIDTH{1'b0}}};
    dsh    = {acc_q, mq_q[WIDTH-1]};
    ge     = dsh >= {1'b0, mb_q};
    ddf    = dsh[WIDTH-1:0] - mb_q;
    st_acc = '0;
    st_mq  = '0;
    if (op_q == OP_MUL) begin
      st_acc = madd[WIDTH:1];
      st_mq  = {madd[0], mq_q[WIDTH-1:1]};
    end else begin
      st_acc = ge ? ddf : dsh[WIDTH-1:0];
      st_mq  = {mq_q[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mb_d    = mb_q;
    res_d   = res_q;
    hi_d    = hi_q;
    cy_d    = cy_q;
    z_d     = z_q;
    n_d     = n_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && iter_op) begin
          op_d    = bus.alu_op;
          acc_d   = '0;
          mq_d    = bus.a;
          mb_d    = bus.b;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ITER;
        end else if (bus.start) begin
          res_d  = s_res;
          hi_d   = s_hi;
          cy_d   = s_cy;
          z_d    = s_zok && (s_res == '0);
          n_d    = s_res[WIDTH-1];
          done_d = 1'b1;
        end
      end
      ITER: begin
        acc_d = st_acc;
        mq_d  = st_mq;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = (op_q == OP_MOD) ? st_acc : st_mq;
          hi_d    = (op_q == OP_MOD) ? st_mq : st_acc;
          cy_d    = (op_q == OP_MUL) && (|st_acc);
          z_d     = (res_d == '0);
          n_d     = res_d[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mb_q    <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      cy_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mb_q    <= mb_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.carry_out = cy_q;
  assign bus.zero      = z_q;
  assign bus.neg       = n_q;
  assign bus.busy      = (state_q == ITER);
  assign bus.done      = done_q;

endmodule
